// File: rtl/snn_aer_pkg.sv
// Shared types and helpers for the spike AER encoder.
// Defines the default widths, the event struct and a saturating adder.
package snn_aer_pkg;

  localparam int AER_NUM_NEURONS = 8;
  localparam int AER_ADDR_W      = $clog2(AER_NUM_NEURONS);
  localparam int AER_TS_W        = 16;
  localparam int AER_FIFO_DEPTH  = 16;
  localparam int AER_DROP_W      = 16;

  typedef struct packed {
    logic [AER_TS_W-1:0]   ts;
    logic [AER_ADDR_W-1:0] addr;
  } aer_event_t;

  // a + inc, clamped to the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] inc,
    input int          w
  );
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, inc};
    max = (w >= 32) ? {1'b0, 32'hFFFF_FFFF}
                    : ((33'd1 << w) - 33'd1);
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous show-ahead event FIFO; push and pop may coincide when full.
// Ports: clk, reset, push/push_data/full, pop/pop_data/empty.
module spike_event_fifo
  import snn_aer_pkg::*;
#(
  parameter int  DEPTH = AER_FIFO_DEPTH,
  parameter type T     = aer_event_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  output logic full,
  input  logic pop,
  output T     pop_data,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T mem [DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        pop_fire;
  logic        push_fire;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop_fire  = pop && !empty;
  // A pop in the same cycle frees the slot being written.
  assign push_fire = push && (!full || pop_fire);

  // Gate the head so the outputs read zero while empty.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Serialises per-timestep neuron spikes into {ts, addr} AER events.
// Ports: clk, reset, spike_strobe, spikes -> aer_valid/ready/addr/ts,
// busy, overflow, drop_count.
module spike_aer_encoder
  import snn_aer_pkg::*;
#(
  parameter int NUM_NEURONS = AER_NUM_NEURONS,
  parameter int ADDR_W      = $clog2(NUM_NEURONS),
  parameter int TS_W        = AER_TS_W,
  parameter int FIFO_DEPTH  = AER_FIFO_DEPTH,
  parameter int DROP_W      = AER_DROP_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   spike_strobe,
  input  logic [NUM_NEURONS-1:0] spikes,
  output logic                   aer_valid,
  input  logic                   aer_ready,
  output logic [ADDR_W-1:0]      aer_addr,
  output logic [TS_W-1:0]        aer_ts,
  output logic                   busy,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [ADDR_W-1:0] addr;
  } ev_t;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [TS_W-1:0]        ts;
  logic [TS_W-1:0]        cur_ts;
  logic [NUM_NEURONS-1:0] pending;
  logic [NUM_NEURONS-1:0] pending_d;
  logic [NUM_NEURONS-1:0] onehot;
  logic [NUM_NEURONS-1:0] remaining;
  logic [ADDR_W-1:0]      lsb_idx;
  logic                   scan_push;
  logic                   push_drop;
  logic                   pop_fire;
  logic [31:0]            drop_inc;

  logic fifo_full;
  logic fifo_empty;
  ev_t  push_ev;
  ev_t  head_ev;

  assign aer_valid = !fifo_empty;
  assign aer_addr  = head_ev.addr;
  assign aer_ts    = head_ev.ts;
  assign busy      = (state_q == SCAN);
  assign pop_fire  = aer_valid && aer_ready;
  assign push_ev   = '{ts: cur_ts, addr: lsb_idx};

  always_comb begin
    lsb_idx = '0;
    for (int i = NUM_NEURONS-1; i >= 0; i--) begin
      if (pending[i]) lsb_idx = ADDR_W'(i);
    end
  end

  always_comb begin
    onehot    = pending & (~pending + NUM_NEURONS'(1));
    scan_push = (state_q == SCAN);
    push_drop = scan_push && fifo_full && !pop_fire;
    remaining = scan_push ? (pending & ~onehot) : pending;
    pending_d = spike_strobe ? spikes : remaining;
    drop_inc  = 32'(push_drop);
    // A new strobe overwrites whatever the scan has not reached yet.
    if (spike_strobe) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        drop_inc = drop_inc + 32'(remaining[i]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|pending_d)  state_d = SCAN;
      SCAN:    if (~|pending_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ts         <= '0;
      cur_ts     <= '0;
      pending    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state_q <= state_d;
      pending <= pending_d;
      if (spike_strobe) begin
        ts     <= ts + TS_W'(1);
        cur_ts <= ts;
      end
      if (drop_inc != 32'd0) begin
        overflow   <= 1'b1;
        drop_count <= DROP_W'(sat_add(32'(drop_count), drop_inc, DROP_W));
      end
    end
  end

  spike_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (ev_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (scan_push),
    .push_data (push_ev),
    .full      (fifo_full),
    .pop       (aer_ready),
    .pop_data  (head_ev),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Scoreboard bench for spike_aer_encoder with directed spike vectors.
// Stimulus queues expected events; a monitor checks each handshake.
module tb_spike_aer_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spike_strobe = 1'b0;
  logic [7:0]  spikes = 8'h00;
  logic        aer_valid;
  logic        aer_ready = 1'b0;
  logic [2:0]  aer_addr;
  logic [15:0] aer_ts;
  logic        busy;
  logic        overflow;
  logic [15:0] drop_count;

  typedef struct {
    logic [15:0] ts;
    logic [2:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  spike_aer_encoder dut (
    .clk          (clk),
    .reset        (reset),
    .spike_strobe (spike_strobe),
    .spikes       (spikes),
    .aer_valid    (aer_valid),
    .aer_ready    (aer_ready),
    .aer_addr     (aer_addr),
    .aer_ts       (aer_ts),
    .busy         (busy),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  // Monitor: an event seen here is consumed at the next rising edge.
  always @(negedge clk) begin
    if (!reset && aer_valid && aer_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got ts=%h addr=%0d, want none",
                 aer_ts, aer_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (aer_ts !== e.ts || aer_addr !== e.addr) begin
          n_fail++;
          $display("FAIL event: got ts=%h addr=%0d, want ts=%h addr=%0d",
                   aer_ts, aer_addr, e.ts, e.addr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic expect_ev(input logic [15:0] t, input logic [2:0] a);
    exp_t e;
    e.ts   = t;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  // Drives a strobe that is sampled at the next edge; returns edge+1.
  task automatic strobe(input logic [7:0] v);
    spike_strobe = 1'b1;
    spikes       = v;
    cycles(1);
    spike_strobe = 1'b0;
    spikes       = 8'h00;
  endtask

  initial begin
    cycles(1);
    do_reset();

    // Reset values.
    chk("rst_valid", 32'(aer_valid), 0);
    chk("rst_addr", 32'(aer_addr), 0);
    chk("rst_ts", 32'(aer_ts), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_count), 0);

    // Three spikes, consecutive events, two-cycle latency.
    aer_ready = 1'b1;
    expect_ev(16'h0000, 3'd2);
    expect_ev(16'h0000, 3'd5);
    expect_ev(16'h0000, 3'd7);
    strobe(8'b1010_0100);
    chk("t1_busy_e0", 32'(busy), 1);
    chk("t1_valid_e0", 32'(aer_valid), 0);
    cycles(1);
    chk("t1_valid_e1", 32'(aer_valid), 1);
    cycles(1);
    chk("t1_valid_e2", 32'(aer_valid), 1);
    chk("t1_busy_e2", 32'(busy), 1);
    cycles(1);
    chk("t1_valid_e3", 32'(aer_valid), 1);
    chk("t1_busy_e3", 32'(busy), 0);
    cycles(1);
    chk("t1_valid_e4", 32'(aer_valid), 0);
    cycles(4);
    chk("t1_drained", exp_q.size(), 0);

    // Empty timestep still advances ts.
    do_reset();
    expect_ev(16'h0001, 3'd0);
    expect_ev(16'h0002, 3'd7);
    strobe(8'h00);
    chk("t2_busy_zero", 32'(busy), 0);
    cycles(11);
    strobe(8'h01);
    cycles(11);
    strobe(8'h80);
    cycles(12);
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_drop", 32'(drop_count), 0);

    // Stalled consumer: FIFO fills, third timestep dropped.
    do_reset();
    aer_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      for (int a = 0; a < 8; a++) expect_ev(16'(t), 3'(a));
    end
    strobe(8'hFF);
    cycles(9);
    strobe(8'hFF);
    cycles(9);
    strobe(8'hFF);
    cycles(10);
    chk("t3_drop", 32'(drop_count), 8);
    chk("t3_overflow", 32'(overflow), 1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(aer_valid), 1);
      chk("t3_hold_addr", 32'(aer_addr), 0);
      chk("t3_hold_ts", 32'(aer_ts), 0);
      cycles(1);
    end
    aer_ready = 1'b1;
    cycles(20);
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_empty", 32'(aer_valid), 0);

    // Strobe while busy discards the unscanned bits.
    do_reset();
    expect_ev(16'h0000, 3'd0);
    expect_ev(16'h0000, 3'd1);
    expect_ev(16'h0000, 3'd2);
    expect_ev(16'h0001, 3'd0);
    strobe(8'hFF);
    cycles(2);
    strobe(8'h01);
    cycles(15);
    chk("t4_drop", 32'(drop_count), 5);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_drained", exp_q.size(), 0);

    // Timestep wrap.
    do_reset();
    force dut.ts = 16'hFFFF;
    cycles(1);
    release dut.ts;
    expect_ev(16'hFFFF, 3'd2);
    expect_ev(16'h0000, 3'd3);
    strobe(8'h04);
    cycles(12);
    strobe(8'h08);
    cycles(12);
    chk("t5_drained", exp_q.size(), 0);

    // Reset in the middle of a scan.
    do_reset();
    aer_ready = 1'b0;
    strobe(8'hFF);
    cycles(2);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    chk("t6_valid", 32'(aer_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_drop", 32'(drop_count), 0);
    chk("t6_overflow", 32'(overflow), 0);
    aer_ready = 1'b1;
    expect_ev(16'h0000, 3'd1);
    strobe(8'h02);
    cycles(10);
    chk("t6_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
